// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetches, decodes ir[31:27] and steps the
// datapath through the register-format ALU instructions one state per cycle.
module control_sequencer #(
    parameter int NREG = 16,
    parameter int NALU = 13
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [31:0]     ir,
    output logic [NREG-1:0] r_out,
    output logic [NREG-1:0] r_in,
    output logic            PCout,
    output logic            PCin,
    output logic            IncPC,
    output logic            MARin,
    output logic            MDRin,
    output logic            MDRout,
    output logic            Read,
    output logic            IRin,
    output logic            Yin,
    output logic            Zin,
    output logic            Zlowout,
    output logic            Zhighout,
    output logic            HIin,
    output logic            LOin,
    output logic [NALU-1:0] alu_op,
    output logic            instr_done,
    output logic            illegal
);

    localparam logic [3:0] IDLE = 4'd0;
    localparam logic [3:0] T0   = 4'd1;
    localparam logic [3:0] T1   = 4'd2;
    localparam logic [3:0] T2   = 4'd3;
    localparam logic [3:0] T3   = 4'd4;
    localparam logic [3:0] T4   = 4'd5;
    localparam logic [3:0] T5   = 4'd6;
    localparam logic [3:0] T6   = 4'd7;
    localparam logic [3:0] HALT = 4'd8;

    logic [3:0]      state_reg, state_next;
    logic            illegal_reg, illegal_next;
    logic [NREG-1:0] ra_hot, rb_hot, rc_hot;
    logic [NALU-1:0] op_hot;
    logic            is_three, is_muldiv, is_unary;

    // One-hot register selects straight from the operand fields.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg_sel
        assign ra_hot[gi] = (ir[26:23] == gi[3:0]);
        assign rb_hot[gi] = (ir[22:19] == gi[3:0]);
        assign rc_hot[gi] = (ir[18:15] == gi[3:0]);
    end

    always_comb begin
        op_hot    = '0;
        is_three  = 1'b0;
        is_muldiv = 1'b0;
        is_unary  = 1'b0;
        case (ir[31:27])
            5'b00011: begin op_hot[10] = 1'b1; is_three  = 1'b1; end
            5'b00100: begin op_hot[9]  = 1'b1; is_three  = 1'b1; end
            5'b00101: begin op_hot[12] = 1'b1; is_three  = 1'b1; end
            5'b00110: begin op_hot[11] = 1'b1; is_three  = 1'b1; end
            5'b00111: begin op_hot[3]  = 1'b1; is_three  = 1'b1; end
            5'b01000: begin op_hot[2]  = 1'b1; is_three  = 1'b1; end
            5'b01001: begin op_hot[6]  = 1'b1; is_three  = 1'b1; end
            5'b01010: begin op_hot[5]  = 1'b1; is_three  = 1'b1; end
            5'b01011: begin op_hot[4]  = 1'b1; is_three  = 1'b1; end
            5'b01111: begin op_hot[8]  = 1'b1; is_muldiv = 1'b1; end
            5'b10000: begin op_hot[7]  = 1'b1; is_muldiv = 1'b1; end
            5'b10001: begin op_hot[1]  = 1'b1; is_unary  = 1'b1; end
            5'b10010: begin op_hot[0]  = 1'b1; is_unary  = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        r_out      = '0;
        r_in       = '0;
        alu_op     = '0;
        PCout      = 1'b0;
        PCin       = 1'b0;
        IncPC      = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        Read       = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zin        = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        instr_done = 1'b0;
        case (state_reg)
            T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1; end
            T1: begin Read = 1'b1; MDRin = 1'b1; end
            T2: begin MDRout = 1'b1; IRin = 1'b1; end
            T3: begin
                if (is_three) begin
                    r_out = rb_hot; Yin = 1'b1;
                end else if (is_muldiv) begin
                    r_out = ra_hot; Yin = 1'b1;
                end else if (is_unary) begin
                    r_out = rb_hot; alu_op = op_hot; Zin = 1'b1;
                end
            end
            T4: begin
                if (is_three) begin
                    r_out = rc_hot; alu_op = op_hot; Zin = 1'b1;
                end else if (is_muldiv) begin
                    r_out = rb_hot; alu_op = op_hot; Zin = 1'b1;
                end else if (is_unary) begin
                    Zlowout = 1'b1; r_in = ra_hot; instr_done = 1'b1;
                end
            end
            T5: begin
                if (is_three) begin
                    Zlowout = 1'b1; r_in = ra_hot; instr_done = 1'b1;
                end else if (is_muldiv) begin
                    Zlowout = 1'b1; LOin = 1'b1;
                end
            end
            T6: begin Zhighout = 1'b1; HIin = 1'b1; instr_done = 1'b1; end
            default: ;
        endcase
    end

    // Unknown opcodes seen in any execute step park the sequencer in HALT.
    always_comb begin
        state_next   = state_reg;
        illegal_next = illegal_reg;
        case (state_reg)
            IDLE: if (run) state_next = T0;
            T0:   state_next = T1;
            T1:   state_next = T2;
            T2:   state_next = T3;
            T3, T4, T5, T6: begin
                if (instr_done) begin
                    state_next = run ? T0 : IDLE;
                end else if (!(is_three || is_muldiv || is_unary) || state_reg == T6) begin
                    state_next   = HALT;
                    illegal_next = 1'b1;
                end else begin
                    state_next = state_reg + 4'd1;
                end
            end
            HALT: state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            illegal_reg <= illegal_next;
        end
    end

    assign illegal = illegal_reg;

endmodule
